multicycle_control_unit: RTL and testbench

- Multi-cycle control FSM for the sequential RV64 core.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, one phase per state.
- Drives datapath enables and handshakes with instruction and data memories whose latency is variable.
- Adds halt and fault detection, per-access timeouts and a retired-instruction counter. The core's ALU still decodes funct fields itself.

---
 rtl/multicycle_control_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Control FSM for the sequential RV64 core. Each instruction moves through
// FETCH, DECODE, EXEC, MEM and WB, one phase per state. Instruction and data
// memories may take a variable number of cycles, and each access has an
// optional timeout. The unit also counts retired instructions and latches
// halt and fault conditions until reset.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   start               begin execution (sampled only in IDLE)
//   instruction         IR contents, valid from DECODE onward
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory access complete
//   zero                ALU equality flag, valid in EXEC
//   imem_req, ir_write  fetch handshake and IR latch
//   pc_write, pc_src    PC update enable and source (0 = PC+4, 1 = PC+imm)
//   alu_src             ALU operand B (0 = rs2, 1 = immediate)
//   dmem_read/write     data memory load/store requests
//   reg_write           register file write enable
//   mem_to_reg          writeback source (1 = memory, 0 = ALU)
//   halted, fault       sticky status flags
//   fault_code          1 = illegal opcode, 2 = fetch timeout, 3 = data timeout
//   state               current state encoding
//   retired_count       saturating count of retired instructions
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction fetch request outstanding
// DECODE | classify opcode, latch class
// EXEC   | ALU operation; branches resolve here
// MEM    | data memory access for loads and stores
// WB     | register writeback and PC+4
// HALT   | all-zero instruction seen; terminal until reset
// FAULT  | illegal opcode or memory timeout; terminal until reset

module multicycle_control_unit #(
  parameter int TIMEOUT    = 16,
  parameter bit EN_TIMEOUT = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      instruction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             zero,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R  = 3'd0,
    C_I  = 3'd1,
    C_LD = 3'd2,
    C_SD = 3'd3,
    C_BR = 3'd4
  } cls_t;

  // Counter value equals (cycle number in state - 1), so the last allowed
  // wait cycle is the one where it reads TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  cls_t       cls_q;
  logic [7:0] wait_cnt;
  logic       timed_out;
  logic       retire;

  assign state     = state_q;
  assign timed_out = EN_TIMEOUT && (wait_cnt == TO_LAST);
  assign retire    = ((state_q == S_EXEC) && (cls_q == C_BR)) ||
                     ((state_q == S_MEM) && (cls_q == C_SD) && dmem_ready) ||
                     (state_q == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cls_q         <= C_R;
      wait_cnt      <= '0;
      retired_count <= '0;
      halted        <= 1'b0;
      fault         <= 1'b0;
      fault_code    <= 2'd0;
    end else begin
      // Saturating so the counter can never wrap back into the timeout window.
      if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
      if (retire && (retired_count != '1)) retired_count <= retired_count + CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_q <= S_DECODE;
          end else if (timed_out) begin
            state_q    <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= 2'd2;
          end
        end
        S_DECODE: begin
          if (instruction == 32'h0) begin
            state_q <= S_HALT;
            halted  <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            case (instruction[6:0])
              7'b0110011: cls_q <= C_R;
              7'b0010011: cls_q <= C_I;
              7'b0000011: cls_q <= C_LD;
              7'b0100011: cls_q <= C_SD;
              7'b1100011: cls_q <= C_BR;
              default: begin
                state_q    <= S_FAULT;
                fault      <= 1'b1;
                fault_code <= 2'd1;
              end
            endcase
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_LD, C_SD: begin
              state_q  <= S_MEM;
              wait_cnt <= '0;
            end
            C_BR: begin
              state_q  <= S_FETCH;
              wait_cnt <= '0;
            end
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (cls_q == C_LD) begin
              state_q <= S_WB;
            end else begin
              state_q  <= S_FETCH;
              wait_cnt <= '0;
            end
          end else if (timed_out) begin
            state_q    <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= 2'd3;
          end
        end
        S_WB: begin
          state_q  <= S_FETCH;
          wait_cnt <= '0;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: begin
        alu_src = (cls_q == C_I) || (cls_q == C_LD) || (cls_q == C_SD);
        if (cls_q == C_BR) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end
      end
      S_MEM: begin
        alu_src    = 1'b1;
        dmem_read  = (cls_q == C_LD);
        dmem_write = (cls_q == C_SD);
        pc_write   = (cls_q == C_SD) && dmem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LD);
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit, built with TIMEOUT=4 so the
// timeout boundaries are reachable in a few cycles.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instruction;
  logic        imem_ready, dmem_ready, zero;
  logic        imem_req, ir_write, pc_write, pc_src, alu_src;
  logic        dmem_read, dmem_write, reg_write, mem_to_reg;
  logic        halted, fault;
  logic [1:0]  fault_code;
  logic [2:0]  state;
  logic [31:0] retired_count;
  logic [8:0]  ctl;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LD   = 32'h0000B103;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SD   = 32'h0020B023;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  multicycle_control_unit #(.TIMEOUT(4), .EN_TIMEOUT(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .halted(halted), .fault(fault), .fault_code(fault_code), .state(state),
    .retired_count(retired_count)
  );

  assign ctl = {imem_req, ir_write, pc_write, pc_src, alu_src,
                dmem_read, dmem_write, reg_write, mem_to_reg};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; instruction = 32'h0;
    imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    #12;
    check_val("rst_state", state, 3'd0);
    check_val("rst_ctl", ctl, 9'd0);
    check_val("rst_cnt", retired_count, 32'd0);
    check_val("rst_flags", {halted, fault, fault_code}, 4'd0);

    // addi: FETCH, DECODE, EXEC, WB, back to FETCH
    nxt();
    rst_n = 1'b1; start = 1'b1; instruction = I_ADDI; imem_ready = 1'b1;
    nxt(); start = 1'b0; #1;
    check_val("addi_fetch", {state, imem_req, ir_write}, {3'd1, 2'b11});
    nxt(); #1; check_val("addi_decode", state, 3'd2);
    nxt(); #1; check_val("addi_exec", {state, alu_src}, {3'd3, 1'b1});
    nxt(); #1;
    check_val("addi_wb", {state, reg_write, pc_write, pc_src, mem_to_reg}, {3'd5, 4'b1100});
    nxt(); #1;
    check_val("addi_ret", {state, retired_count}, {3'd1, 32'd1});

    // ld with two data wait cycles: retires in cycle 7 after FETCH entry
    instruction = I_LD; dmem_ready = 1'b0;
    nxt(); #1; check_val("ld_decode", state, 3'd2);
    nxt(); #1; check_val("ld_exec", {state, alu_src}, {3'd3, 1'b1});
    nxt(); #1; check_val("ld_mem1", {state, dmem_read, alu_src}, {3'd4, 2'b11});
    nxt(); #1; check_val("ld_mem2", {state, dmem_read}, {3'd4, 1'b1});
    nxt(); dmem_ready = 1'b1; #1;
    check_val("ld_mem3", {state, dmem_read}, {3'd4, 1'b1});
    nxt(); dmem_ready = 1'b0; #1;
    check_val("ld_wb", {state, reg_write, mem_to_reg, pc_write}, {3'd5, 3'b111});
    nxt(); #1;
    check_val("ld_ret", {state, retired_count}, {3'd1, 32'd2});

    // beq taken then not taken
    instruction = I_BEQ; zero = 1'b1;
    nxt(); nxt(); #1;
    check_val("beq1_exec", {state, pc_write, pc_src, reg_write, alu_src}, {3'd3, 4'b1100});
    zero = 1'b0;
    nxt(); #1; check_val("beq1_next", state, 3'd1);
    nxt(); nxt(); #1;
    check_val("beq0_exec", {state, pc_write, pc_src, reg_write}, {3'd3, 3'b100});
    nxt(); #1;
    check_val("beq_ret", {state, retired_count}, {3'd1, 32'd4});

    // illegal opcode -> FAULT, start ignored, reset clears
    instruction = I_BAD;
    nxt(); nxt(); #1;
    check_val("ill_fault", {state, fault, fault_code, halted}, {3'd7, 1'b1, 2'd1, 1'b0});
    check_val("ill_ctl", ctl, 9'd0);
    start = 1'b1;
    nxt(); start = 1'b0;
    nxt(); #1;
    check_val("ill_sticky", {state, fault, retired_count}, {3'd7, 1'b1, 32'd4});
    rst_n = 1'b0; #1;
    check_val("ill_reset", {state, fault, fault_code, retired_count}, {3'd0, 1'b0, 2'd0, 32'd0});

    // all-zero instruction -> HALT
    nxt();
    rst_n = 1'b1; start = 1'b1; instruction = 32'h0; imem_ready = 1'b1;
    nxt(); start = 1'b0;
    nxt(); nxt(); #1;
    check_val("halt", {state, halted, fault, ctl}, {3'd6, 1'b1, 1'b0, 9'd0});
    do_reset();

    // fetch timeout: imem_req for 4 cycles then FAULT code 2
    imem_ready = 1'b0; start = 1'b1;
    nxt(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; check_val("fto_req", {state, imem_req}, {3'd1, 1'b1});
      nxt();
    end
    #1;
    check_val("fto_fault", {state, fault, fault_code, imem_req}, {3'd7, 1'b1, 2'd2, 1'b0});
    do_reset();

    // ready in cycle 4 completes; then a zero-wait store retires from MEM
    imem_ready = 1'b0; start = 1'b1; instruction = I_SD; dmem_ready = 1'b1;
    nxt(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check_val("fok_req", {state, imem_req, ir_write}, {3'd1, 2'b10});
      nxt();
    end
    imem_ready = 1'b1; #1;
    check_val("fok_irw", {state, ir_write}, {3'd1, 1'b1});
    nxt(); #1; check_val("fok_decode", {state, fault}, {3'd2, 1'b0});
    nxt(); #1; check_val("sd_exec", {state, alu_src}, {3'd3, 1'b1});
    nxt(); #1;
    check_val("sd_mem", {state, dmem_write, pc_write, pc_src, alu_src}, {3'd4, 4'b1101});
    nxt(); #1;
    check_val("sd_ret", {state, retired_count}, {3'd1, 32'd1});

    // data timeout: dmem_write for 4 cycles then FAULT code 3
    dmem_ready = 1'b0;
    nxt(); nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      #1; check_val("dto_req", {state, dmem_write}, {3'd4, 1'b1});
      nxt();
    end
    #1;
    check_val("dto_fault", {state, fault, fault_code}, {3'd7, 1'b1, 2'd3});
    do_reset();

    // reset asserted mid-store drops every output before the next edge
    start = 1'b1;
    nxt(); start = 1'b0;
    nxt(); nxt(); nxt(); #1;
    check_val("mid_mem", {state, dmem_write}, {3'd4, 1'b1});
    rst_n = 1'b0; #1;
    check_val("mid_rst", {state, ctl, halted, fault, fault_code}, {3'd0, 9'd0, 4'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
